// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: request type, latency bound and index-width helper for mem_responder.
`include "config.svh"
package mem_responder_pkg;
  localparam int XLEN = `XLEN;
  localparam int MAX_READ_LATENCY = 4;
  typedef struct packed {
    logic              write;
    logic [XLEN/8-1:0] wstrb;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
  } mem_req_t;
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/config.svh
// config.svh: global configuration shared by the memory responder and its users.
`ifndef CONFIG_SVH
`define CONFIG_SVH
`define XLEN 32
`endif

// File: rtl/mem_resp_delay_line.sv
// mem_resp_delay_line: LATENCY-stage {valid, data} shift register; output data holds between pulses.
module mem_resp_delay_line #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] word,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    logic             v;
    logic [WIDTH-1:0] d;
    logic             vi;
    logic [WIDTH-1:0] di;
    if (i == 0) begin : g_head
      assign vi = push;
      assign di = word;
    end else begin : g_tail
      assign vi = g_stage[i-1].v;
      assign di = g_stage[i-1].d;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) v <= 1'b0;
      else v <= vi;
    // only the visible stage needs a defined reset value
    if (i == LATENCY - 1) begin : g_out
      always_ff @(posedge clk or posedge rst)
        if (rst) d <= '0;
        else if (vi) d <= di;
    end else begin : g_mid
      always_ff @(posedge clk)
        if (vi) d <= di;
    end
  end
  assign valid = g_stage[LATENCY-1].v;
  assign data  = g_stage[LATENCY-1].d;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word RAM with byte-strobe writes and fixed-latency in-order read responses.
// Define MEM_RESPONDER_STALL_EN to drop ready for one cycle in every STALL_PERIOD cycles.
`include "config.svh"
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 1,
  parameter int STALL_PERIOD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              write,
  input  logic [XLEN/8-1:0] wstrb,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [XLEN-1:0]   rdata
);
  localparam int AW = idx_width(DEPTH);
  mem_req_t        r;
  logic [AW-1:0]   idx;
  logic [XLEN-1:0] mem [DEPTH];
  logic            up;
  logic            fire;
  logic            unused_addr;
  assign r           = '{write: write, wstrb: wstrb, addr: addr, wdata: wdata};
  assign idx         = r.addr[AW+1:2];
  assign unused_addr = ^{r.addr[XLEN-1:AW+2], r.addr[1:0]};
  assign fire        = req & ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) up <= 1'b0;
    else up <= 1'b1;
`ifdef MEM_RESPONDER_STALL_EN
  localparam int CW = $clog2(STALL_PERIOD);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (cnt == CW'(STALL_PERIOD - 1)) ? '0 : cnt + 1'b1;
  assign ready = up & (cnt != CW'(STALL_PERIOD - 1));
`else
  assign ready = up;
`endif
  always_ff @(posedge clk)
    if (fire && r.write)
      for (int b = 0; b < XLEN/8; b++)
        if (r.wstrb[b]) mem[idx][8*b +: 8] <= r.wdata[8*b +: 8];
  // the first stage samples the array on the accept edge, so a same-edge write is not seen
  mem_resp_delay_line #(.LATENCY(READ_LATENCY), .WIDTH(XLEN)) u_delay (
    .clk  (clk),
    .rst  (rst),
    .push (fire & ~r.write),
    .word (mem[idx]),
    .valid(rvalid),
    .data (rdata)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two responders (read latency 1 and 3) on shared stimulus, checked by a queue scoreboard.
module tb_mem_responder;
  localparam int DEPTH = 64;
  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;
  logic        clk = 0;
  logic        rst = 0;
  logic        req = 0;
  logic        write = 0;
  logic [3:0]  wstrb = 0;
  logic [31:0] addr = 0;
  logic [31:0] wdata = 0;
  logic        rdy [2];
  logic        rv [2];
  logic [31:0] rd [2];
  logic [31:0] mem_m [DEPTH];
  exp_t        q [2][$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  wire         ready = rdy[0] & rdy[1];

  mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .write(write), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .ready(rdy[0]), .rvalid(rv[0]), .rdata(rd[0]));
  mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .write(write), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .ready(rdy[1]), .rvalid(rv[1]), .rdata(rd[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int j = 0; j < 2; j++) begin
      if (rv[j]) begin
        if (q[j].size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_rvalid dut%0d: got rdata %h expected no response", j, rd[j]);
        end else begin
          e = q[j].pop_front();
          check($sformatf("rdata_dut%0d", j), rd[j], e.d);
          check($sformatf("rvalid_cycle_dut%0d", j), cyc, e.due);
        end
      end else if (q[j].size() > 0 && q[j][0].due < cyc) begin
        e = q[j].pop_front();
        compared++;
        mismatched++;
        $display("FAIL missing_rvalid dut%0d: got none expected %h at cycle %0d", j, e.d, e.due);
      end
    end
  end

  task automatic model(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    int i = int'((a >> 2) % DEPTH);
    logic [31:0] m = 0;
    if (w) begin
      for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
      mem_m[i] = (mem_m[i] & ~m) | (d & m);
    end else begin
      q[0].push_back('{mem_m[i], cyc + 1});
      q[1].push_back('{mem_m[i], cyc + 3});
    end
  endtask

  task automatic xfer(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    int k = 0;
    req = 1; write = w; wstrb = s; addr = a; wdata = d;
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got ready=0 for %0d cycles expected acceptance", k);
    end else model(w, s, a, d);
    @(negedge clk);
    req = 0; write = 1'($urandom); wstrb = 4'($urandom); wdata = $urandom;
  endtask

  task automatic idle(input int n);
    req = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    q[0].delete();
    q[1].delete();
    #1;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 2; j++) begin
        check($sformatf("rst_ready_dut%0d", j), 32'(rdy[j]), 0);
        check($sformatf("rst_rvalid_dut%0d", j), 32'(rv[j]), 0);
        check($sformatf("rst_rdata_dut%0d", j), rd[j], 0);
      end
      @(negedge clk);
    end
    rst = 0;
    @(negedge clk);
    for (int j = 0; j < 2; j++) check($sformatf("ready_after_rst_dut%0d", j), 32'(rdy[j]), 1);
  endtask

  task automatic stream12();
    int acc = 0;
    logic [31:0] a = $urandom;
    for (int k = 0; k < 12; k++) begin
      req = 1; write = 0; addr = a;
      if (ready) begin
        model(0, 0, a, 0);
        acc++;
        a = $urandom;
      end
      @(negedge clk);
    end
    req = 0;
`ifdef MEM_RESPONDER_STALL_EN
    check("stream_accepts", acc, 9);
`else
    check("stream_accepts", acc, 12);
`endif
  endtask

  initial begin
    #1 rst = 1;
    @(negedge clk);
    do_reset(5);
    idle(4);
    for (int i = 0; i < DEPTH; i++) xfer(1, 4'hF, 32'(i * 4), $urandom);
    xfer(1, 4'hF, 32'h10, 32'hDEADBEEF);
    xfer(0, 4'h0, 32'h10, 0);
    idle(5);
    xfer(1, 4'hF, 32'h40, 32'h11223344);
    xfer(1, 4'b0101, 32'h40, 32'hAABBCCDD);
    xfer(0, 4'h0, 32'h40, 0);
    xfer(1, 4'h0, 32'h40, 32'h0);
    xfer(0, 4'h0, 32'h40, 0);
    idle(5);
    for (int i = 0; i < 4; i++) xfer(1, 4'hF, 32'(i * 4), 32'(i));
    xfer(0, 0, 32'h0, 0);
    xfer(0, 0, 32'h4, 0);
    xfer(0, 0, 32'(DEPTH * 4 + 8), 0);
    xfer(0, 0, 32'hC, 0);
    idle(5);
    xfer(1, 4'hF, 32'h20, 32'h5);
    xfer(0, 0, 32'h20, 0);
    xfer(1, 4'hF, 32'h20, 32'h9);
    xfer(0, 0, 32'h20, 0);
    idle(5);
    for (int n = 0; n < 200; n++) begin
      xfer(1'($urandom), 4'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    idle(5);
    stream12();
    idle(6);
    xfer(0, 0, 32'h10, 0);
    @(negedge clk);
    do_reset(2);
    idle(8);
    check("queue_dut1_drained", q[0].size(), 0);
    check("queue_dut3_drained", q[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
